// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiply-accumulate: Product = M * Q_in + R_in.
// One shift-add iteration per clock, then a final cycle folds in the addend.
module shift_add_multiplier #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   M,
  input  logic [N-1:0]   Q_in,
  input  logic [N-1:0]   R_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] Product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ADD
  } state_t;

  state_t        state;
  logic [N-1:0]  mr;
  logic [N-1:0]  rr;
  logic [N-1:0]  qr;
  logic [N:0]    acc;
  logic [CW-1:0] count;
  logic [N:0]    sum;

  // The accumulator top bit is always zero after a shift, so this add cannot overflow N+1 bits.
  always_comb begin
    sum = acc;
    if (qr[0]) begin
      sum = acc + {1'b0, mr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mr      <= '0;
      rr      <= '0;
      qr      <= '0;
      acc     <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mr    <= M;
            rr    <= R_in;
            qr    <= Q_in;
            acc   <= '0;
            count <= CW'(N);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Right shift of {sum, qr}; the low partial-product bit migrates into qr.
          acc   <= {1'b0, sum[N:1]};
          qr    <= {sum[0], qr[N-1:1]};
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= ADD;
          end
        end
        ADD: begin
          Product <= {acc[N-1:0], qr} + {{N{1'b0}}, rr};
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier at N = 8, 16 and 32, compared
// against a plain-arithmetic multiply-accumulate model.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start;
  logic [31:0] mIn [3];
  logic [31:0] qIn [3];
  logic [31:0] rIn [3];
  wire  [2:0]  busyV;
  wire  [2:0]  doneV;
  wire  [15:0] prod8;
  wire  [31:0] prod16;
  wire  [63:0] prod32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.N(8)) u8 (
    .clk(clk), .rst(rst), .start(start[0]),
    .M(mIn[0][7:0]), .Q_in(qIn[0][7:0]), .R_in(rIn[0][7:0]),
    .busy(busyV[0]), .done(doneV[0]), .Product(prod8)
  );

  shift_add_multiplier #(.N(16)) u16 (
    .clk(clk), .rst(rst), .start(start[1]),
    .M(mIn[1][15:0]), .Q_in(qIn[1][15:0]), .R_in(rIn[1][15:0]),
    .busy(busyV[1]), .done(doneV[1]), .Product(prod16)
  );

  shift_add_multiplier #(.N(32)) u32 (
    .clk(clk), .rst(rst), .start(start[2]),
    .M(mIn[2]), .Q_in(qIn[2]), .R_in(rIn[2]),
    .busy(busyV[2]), .done(doneV[2]), .Product(prod32)
  );

  function automatic int widthOf(input int w);
    return (w == 0) ? 8 : (w == 1) ? 16 : 32;
  endfunction

  function automatic logic [63:0] getProd(input int w);
    case (w)
      0:       return {48'b0, prod8};
      1:       return {32'b0, prod16};
      default: return prod32;
    endcase
  endfunction

  // Reference: the whole result is just multiply then add, done in 64-bit arithmetic.
  function automatic logic [63:0] refModel(input int w, input logic [31:0] m,
                                           input logic [31:0] q, input logic [31:0] r);
    logic [63:0] mask;
    mask = (64'd1 << widthOf(w)) - 64'd1;
    return (({32'b0, m} & mask) * ({32'b0, q} & mask)) + ({32'b0, r} & mask);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called just after a falling edge; returns edges from accept to done.
  task automatic applyStimulus(input int w, input logic [31:0] m, input logic [31:0] q,
                               input logic [31:0] r, output int lat, output int busyCnt,
                               output logic [63:0] prod);
    mIn[w]   = m;
    qIn[w]   = q;
    rIn[w]   = r;
    start[w] = 1'b1;
    lat      = -1;
    busyCnt  = 0;
    for (int e = 1; e <= widthOf(w) + 10; e++) begin
      @(negedge clk);
      if (e == 1) start[w] = 1'b0;
      if (busyV[w]) busyCnt++;
      if (doneV[w]) begin
        lat = e - 1;
        break;
      end
    end
    prod = getProd(w);
  endtask

  initial begin
    int          lat;
    int          busyCnt;
    int          doneCnt;
    int          gap;
    logic [63:0] prod;
    logic [31:0] m;
    logic [31:0] q;
    logic [31:0] r;

    rst   = 1'b1;
    start = '0;
    for (int i = 0; i < 3; i++) begin
      mIn[i] = '0;
      qIn[i] = '0;
      rIn[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset_busy%0d", i), {63'b0, busyV[i]}, 64'd0);
      checkOutput($sformatf("reset_done%0d", i), {63'b0, doneV[i]}, 64'd0);
      checkOutput($sformatf("reset_prod%0d", i), getProd(i), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // N=32 directed cases
    applyStimulus(2, 32'd5, 32'd60, 32'd4, lat, busyCnt, prod);
    checkOutput("n32_basic_prod", prod, 64'd304);
    checkOutput("n32_basic_lat", 64'(lat), 64'd33);
    checkOutput("n32_basic_busy", 64'(busyCnt), 64'd33);

    applyStimulus(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busyCnt, prod);
    checkOutput("n32_max_prod", prod, 64'hFFFF_FFFF_0000_0000);
    checkOutput("n32_max_lat", 64'(lat), 64'd33);

    applyStimulus(2, 32'd0, 32'd0, 32'd0, lat, busyCnt, prod);
    checkOutput("n32_zero_prod", prod, 64'd0);
    checkOutput("n32_zero_lat", 64'(lat), 64'd33);

    for (int i = 0; i < 4; i++) begin
      m = $urandom;
      q = $urandom;
      r = $urandom;
      applyStimulus(2, m, q, r, lat, busyCnt, prod);
      checkOutput("n32_rand_prod", prod, refModel(2, m, q, r));
    end

    // N=8: start re-asserted and operands changed while running
    mIn[0]   = 32'd3;
    qIn[0]   = 32'd7;
    rIn[0]   = 32'd2;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    mIn[0]   = 32'd9;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    doneCnt  = 0;
    prod     = '0;
    for (int e = 0; e < 25; e++) begin
      @(negedge clk);
      if (doneV[0]) begin
        doneCnt++;
        prod = getProd(0);
      end
    end
    checkOutput("n8_ignore_donecnt", 64'(doneCnt), 64'd1);
    checkOutput("n8_ignore_prod", prod, 64'd23);

    // N=8 back-to-back: second start raised in the done cycle
    applyStimulus(0, 32'd6, 32'd11, 32'd5, lat, busyCnt, prod);
    checkOutput("n8_b2b_first_prod", prod, 64'd71);
    mIn[0]   = 32'd10;
    qIn[0]   = 32'd10;
    rIn[0]   = 32'd0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    checkOutput("n8_b2b_busy_rise", {63'b0, busyV[0]}, 64'd1);
    checkOutput("n8_b2b_done_fall", {63'b0, doneV[0]}, 64'd0);
    gap = -1;
    for (int e = 2; e <= 20; e++) begin
      @(negedge clk);
      if (e == 5) checkOutput("n8_b2b_prod_held", getProd(0), 64'd71);
      if (doneV[0]) begin
        gap = e;
        break;
      end
    end
    checkOutput("n8_b2b_gap", 64'(gap), 64'd10);
    checkOutput("n8_b2b_second_prod", getProd(0), 64'd100);

    // N=8 reset mid-operation, with a start on the reset edge
    mIn[0]   = 32'd200;
    qIn[0]   = 32'd200;
    rIn[0]   = 32'd100;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst      = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    start[0] = 1'b0;
    checkOutput("n8_rst_busy", {63'b0, busyV[0]}, 64'd0);
    checkOutput("n8_rst_done", {63'b0, doneV[0]}, 64'd0);
    checkOutput("n8_rst_prod", getProd(0), 64'd0);
    doneCnt = 0;
    for (int e = 0; e < 15; e++) begin
      @(negedge clk);
      if (doneV[0]) doneCnt++;
    end
    checkOutput("n8_rst_nodone", 64'(doneCnt), 64'd0);
    applyStimulus(0, 32'd13, 32'd17, 32'd6, lat, busyCnt, prod);
    checkOutput("n8_after_rst_prod", prod, 64'd227);
    checkOutput("n8_after_rst_lat", 64'(lat), 64'd9);

    // N=16 randomized, with a divide check recovering quotient and remainder
    for (int i = 0; i < 1000; i++) begin
      m = $urandom_range(65535, 1);
      q = $urandom_range(65535, 0);
      r = $urandom_range(m - 1, 0);
      applyStimulus(1, m, q, r, lat, busyCnt, prod);
      checkOutput($sformatf("n16_rand_prod_%0d", i), prod, refModel(1, m, q, r));
      checkOutput($sformatf("n16_rand_lat_%0d", i), 64'(lat), 64'd17);
      checkOutput($sformatf("n16_rand_div_%0d", i),
                  {prod / {32'b0, m}, prod % {32'b0, m}} >> 0 == {64'(q), 64'(r)} ? 64'd1 : 64'd0,
                  64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
